lru_matrix_replacer: RTL and testbench

- Parametrised successor to the 4-way square-matrix LRU replacer: WAYS-way, SETS-set true-LRU replacement engine for set-associative caches.
- Holds one WAYS x WAYS age matrix per set. Accepts touch/invalidate updates and victim queries, and returns a registered victim one cycle after each query.
- Adds per-way locking, explicit invalidation (force-to-LRU), and an allocate mode that marks the returned victim MRU automatically.
- Sits between the cache tag/hit logic and the fill controller.

---
 rtl/lru_pkg.sv | 33 +++
 rtl/lru_victim_sel.sv | 33 +++
 rtl/lru_matrix_replacer.sv | 139 +++++++++++++
 tb/tb_lru_matrix_replacer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/lru_pkg.sv
// rtl/lru_pkg.sv - shared opcodes and helpers for the LRU replacement engines
package lru_pkg;

  localparam logic LRU_OP_TOUCH = 1'b0;
  localparam logic LRU_OP_INVAL = 1'b1;

  // Widest row the reset-order helper can produce (upper bound on WAYS).
  localparam int LRU_MAX_WAYS = 16;

  // Ceiling log2 for elaboration-time width derivation.
  function automatic int lru_clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) r++;
    return r;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int lru_idx_w(input int n);
    return (n <= 2) ? 1 : lru_clog2(n);
  endfunction

  // Reset row for a way: newer than every lower-index way, so way0 is LRU.
  function automatic logic [LRU_MAX_WAYS-1:0] lru_reset_row(input int way);
    logic [LRU_MAX_WAYS-1:0] row;
    row = '0;
    for (int j = 0; j < LRU_MAX_WAYS; j++) begin
      if (j < way) row[j] = 1'b1;
    end
    return row;
  endfunction

endpackage

// File: rtl/lru_victim_sel.sv
// rtl/lru_victim_sel.sv - combinational victim pick from an age matrix and lock mask
module lru_victim_sel
  import lru_pkg::*;
#(
  parameter int WAYS  = 4,
  parameter int WAY_W = lru_idx_w(WAYS)
) (
  input  logic [WAYS*WAYS-1:0] i_rows,
  input  logic [WAYS-1:0]      i_lock_mask,
  output logic [WAY_W-1:0]     o_way,
  output logic                 o_none
);

  logic [WAYS-1:0] w_unlocked;
  logic            w_found;

  assign w_unlocked = ~i_lock_mask;

  // Lowest unlocked way that is newer than no other unlocked way.
  always_comb begin
    o_way   = '0;
    o_none  = ~|w_unlocked;
    w_found = 1'b0;
    for (int v = 0; v < WAYS; v++) begin
      if (!w_found && w_unlocked[v] &&
          ((i_rows[v*WAYS +: WAYS] & w_unlocked) == '0)) begin
        o_way   = WAY_W'(v);
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lru_matrix_replacer.sv
// rtl/lru_matrix_replacer.sv - WAYS x SETS true-LRU matrix replacer with lock and allocate
module lru_matrix_replacer
  import lru_pkg::*;
#(
  parameter int WAYS  = 4,
  parameter int SETS  = 4,
  parameter int WAY_W = lru_idx_w(WAYS),
  parameter int SET_W = lru_idx_w(SETS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             upd_valid,
  output logic             upd_ready,
  input  logic [SET_W-1:0] upd_set,
  input  logic [WAY_W-1:0] upd_way,
  input  logic             upd_op,
  input  logic             qry_valid,
  output logic             qry_ready,
  input  logic [SET_W-1:0] qry_set,
  input  logic             qry_alloc,
  input  logic [WAYS-1:0]  lock_mask,
  output logic             vic_valid,
  output logic [WAY_W-1:0] vic_way,
  output logic             vic_none
);

  // r_mat[s][i][j] = 1 when way i is more recent than way j in set s.
  logic [WAYS-1:0]      r_mat [SETS][WAYS];

  logic                 r_pend_valid;
  logic [SET_W-1:0]     r_pend_set;
  logic [WAY_W-1:0]     r_pend_way;
  logic                 r_vic_valid;
  logic [WAY_W-1:0]     r_vic_way;
  logic                 r_vic_none;

  logic                 w_upd_fire;
  logic                 w_qry_fire;
  logic                 w_upd_in_range;
  logic                 w_qry_in_range;
  logic [SET_W-1:0]     w_upd_set_idx;
  logic [SET_W-1:0]     w_qry_set_idx;
  logic [WAYS*WAYS-1:0] w_qry_rows;
  logic [WAY_W-1:0]     w_sel_way;
  logic                 w_sel_none;

  // New value of row i when way k is touched (made MRU) or invalidated (made LRU).
  function automatic logic [WAYS-1:0] f_upd_row(input logic [WAYS-1:0] row,
                                                input logic row_is_k,
                                                input logic [WAY_W-1:0] k,
                                                input logic op);
    logic [WAYS-1:0] oh;
    logic [WAYS-1:0] r;
    oh = {{(WAYS-1){1'b0}}, 1'b1} << k;
    if (row_is_k) r = (op == LRU_OP_TOUCH) ? ~oh : '0;
    else          r = (op == LRU_OP_TOUCH) ? (row & ~oh) : (row | oh);
    return r;
  endfunction

  // A pending allocate touch stalls only requests aimed at its own set.
  assign upd_ready = !(r_pend_valid && (upd_set == r_pend_set));
  assign qry_ready = !(r_pend_valid && (qry_set == r_pend_set));

  assign w_upd_fire     = upd_valid && upd_ready;
  assign w_qry_fire     = qry_valid && qry_ready;
  assign w_upd_in_range = (32'(upd_set) < 32'(SETS)) && (32'(upd_way) < 32'(WAYS));
  assign w_qry_in_range = (32'(qry_set) < 32'(SETS));
  assign w_upd_set_idx  = w_upd_in_range ? upd_set : '0;
  assign w_qry_set_idx  = w_qry_in_range ? qry_set : '0;

  // Flatten the queried set's rows for the selector (read-before-write).
  always_comb begin
    w_qry_rows = '0;
    for (int i = 0; i < WAYS; i++) begin
      w_qry_rows[i*WAYS +: WAYS] = r_mat[w_qry_set_idx][i];
    end
  end

  lru_victim_sel #(
    .WAYS  (WAYS),
    .WAY_W (WAY_W)
  ) u_victim_sel (
    .i_rows      (w_qry_rows),
    .i_lock_mask (lock_mask),
    .o_way       (w_sel_way),
    .o_none      (w_sel_none)
  );

  // Matrix storage: external update and allocate touch never target the same set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SETS; s++) begin
        for (int i = 0; i < WAYS; i++) begin
          r_mat[s][i] <= WAYS'(lru_reset_row(i));
        end
      end
    end else begin
      if (w_upd_fire && w_upd_in_range) begin
        for (int i = 0; i < WAYS; i++) begin
          r_mat[w_upd_set_idx][i] <= f_upd_row(r_mat[w_upd_set_idx][i],
                                               (i == int'(upd_way)), upd_way, upd_op);
        end
      end
      if (r_pend_valid) begin
        for (int i = 0; i < WAYS; i++) begin
          r_mat[r_pend_set][i] <= f_upd_row(r_mat[r_pend_set][i],
                                            (i == int'(r_pend_way)), r_pend_way,
                                            LRU_OP_TOUCH);
        end
      end
    end
  end

  // Registered victim response and the one-cycle pending allocate touch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vic_valid  <= 1'b0;
      r_vic_way    <= '0;
      r_vic_none   <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_set   <= '0;
      r_pend_way   <= '0;
    end else begin
      r_vic_valid  <= w_qry_fire;
      r_pend_valid <= w_qry_fire && qry_alloc && w_qry_in_range && !w_sel_none;
      r_pend_set   <= w_qry_set_idx;
      r_pend_way   <= w_sel_way;
      if (w_qry_fire) begin
        r_vic_way  <= (w_qry_in_range && !w_sel_none) ? w_sel_way : '0;
        r_vic_none <= !w_qry_in_range || w_sel_none;
      end
    end
  end

  assign vic_valid = r_vic_valid;
  assign vic_way   = r_vic_way;
  assign vic_none  = r_vic_none;

endmodule

// File: tb/tb_lru_matrix_replacer.sv
// tb/tb_lru_matrix_replacer.sv - scoreboard bench for the LRU matrix replacer
module tb_lru_matrix_replacer;
  import lru_pkg::*;

  localparam int WAYS  = 4;
  localparam int SETS  = 4;
  localparam int WAY_W = 2;
  localparam int SET_W = 2;

  logic             clk;
  logic             reset;
  logic             upd_valid;
  logic             upd_ready;
  logic [SET_W-1:0] upd_set;
  logic [WAY_W-1:0] upd_way;
  logic             upd_op;
  logic             qry_valid;
  logic             qry_ready;
  logic [SET_W-1:0] qry_set;
  logic             qry_alloc;
  logic [WAYS-1:0]  lock_mask;
  logic             vic_valid;
  logic [WAY_W-1:0] vic_way;
  logic             vic_none;

  int total = 0;
  int bad   = 0;
  logic [WAY_W:0] exp_q[$];
  logic [WAY_W:0] sb_e;

  lru_matrix_replacer #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .upd_valid (upd_valid),
    .upd_ready (upd_ready),
    .upd_set   (upd_set),
    .upd_way   (upd_way),
    .upd_op    (upd_op),
    .qry_valid (qry_valid),
    .qry_ready (qry_ready),
    .qry_set   (qry_set),
    .qry_alloc (qry_alloc),
    .lock_mask (lock_mask),
    .vic_valid (vic_valid),
    .vic_way   (vic_way),
    .vic_none  (vic_none)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Scoreboard: every response strobe pops and compares one expectation.
  always @(negedge clk) begin
    if (reset && vic_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got way=%0d none=%0b, required no response", vic_way, vic_none);
      end else begin
        sb_e = exp_q.pop_front();
        if ({vic_way, vic_none} !== sb_e) begin
          bad++;
          $display("FAIL sb_victim: got way=%0d none=%0b, required way=%0d none=%0b",
                   vic_way, vic_none, sb_e[WAY_W:1], sb_e[0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    upd_valid = 1'b0; upd_set = '0; upd_way = '0; upd_op = LRU_OP_TOUCH;
    qry_valid = 1'b0; qry_set = '0; qry_alloc = 1'b0; lock_mask = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    tick();
    tick();
    exp_q.delete();
    reset = 1'b1;
  endtask

  task automatic send_update(input logic [SET_W-1:0] s, input logic [WAY_W-1:0] w, input logic op);
    upd_valid = 1'b1; upd_set = s; upd_way = w; upd_op = op;
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic send_query(input logic [SET_W-1:0] s, input logic alloc, input logic [WAYS-1:0] lock,
                            input logic [WAY_W-1:0] ew, input logic en);
    qry_valid = 1'b1; qry_set = s; qry_alloc = alloc; lock_mask = lock;
    exp_q.push_back({ew, en});
    tick();
    qry_valid = 1'b0; qry_alloc = 1'b0; lock_mask = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (vic_valid !== 1'b0) begin bad++; $display("FAIL reset_vic_valid: got %0b, required 0", vic_valid); end
    total++; if (vic_way !== 2'd0) begin bad++; $display("FAIL reset_vic_way: got %0d, required 0", vic_way); end
    total++; if (vic_none !== 1'b0) begin bad++; $display("FAIL reset_vic_none: got %0b, required 0", vic_none); end
    total++; if (upd_ready !== 1'b1) begin bad++; $display("FAIL reset_upd_ready: got %0b, required 1", upd_ready); end
    total++; if (qry_ready !== 1'b1) begin bad++; $display("FAIL reset_qry_ready: got %0b, required 1", qry_ready); end
    tick();
    reset = 1'b1;
    send_query(2'd2, 1'b0, 4'b0000, 2'd0, 1'b0);
    @(negedge clk);
    total++; if (vic_valid !== 1'b1) begin bad++; $display("FAIL resp_strobe_on: got %0b, required 1", vic_valid); end
    tick();
    @(negedge clk);
    total++; if (vic_valid !== 1'b0) begin bad++; $display("FAIL resp_strobe_off: got %0b, required 0", vic_valid); end
    tick();
  endtask

  task automatic test_touch_inval();
    do_reset();
    send_update(2'd1, 2'd0, LRU_OP_TOUCH);
    send_update(2'd1, 2'd2, LRU_OP_TOUCH);
    send_update(2'd1, 2'd3, LRU_OP_TOUCH);
    send_query(2'd1, 1'b0, 4'b0000, 2'd1, 1'b0);
    send_update(2'd1, 2'd3, LRU_OP_INVAL);
    send_query(2'd1, 1'b0, 4'b0000, 2'd3, 1'b0);
    tick();
  endtask

  task automatic test_lock();
    do_reset();
    send_query(2'd0, 1'b0, 4'b0001, 2'd1, 1'b0);
    send_query(2'd0, 1'b0, 4'b1111, 2'd0, 1'b1);
    send_query(2'd0, 1'b0, 4'b0111, 2'd3, 1'b0);
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    qry_valid = 1'b1; qry_set = 2'd0; qry_alloc = 1'b1;
    exp_q.push_back({2'd0, 1'b0});
    tick();
    #1;
    total++; if (qry_ready !== 1'b0) begin bad++; $display("FAIL b2b_qry_stall: got %0b, required 0", qry_ready); end
    upd_set = 2'd0;
    #1;
    total++; if (upd_ready !== 1'b0) begin bad++; $display("FAIL b2b_upd_stall: got %0b, required 0", upd_ready); end
    upd_set = 2'd1;
    #1;
    total++; if (upd_ready !== 1'b1) begin bad++; $display("FAIL b2b_upd_other_set: got %0b, required 1", upd_ready); end
    upd_set = 2'd0;
    tick();
    exp_q.push_back({2'd1, 1'b0});
    #1;
    total++; if (qry_ready !== 1'b1) begin bad++; $display("FAIL b2b_qry_resume: got %0b, required 1", qry_ready); end
    tick();
    qry_valid = 1'b0; qry_alloc = 1'b0;
    tick();
    send_query(2'd0, 1'b0, 4'b0000, 2'd2, 1'b0);
    tick();

    do_reset();
    qry_valid = 1'b1; qry_set = 2'd0; qry_alloc = 1'b1;
    exp_q.push_back({2'd0, 1'b0});
    tick();
    qry_set = 2'd3;
    #1;
    total++; if (qry_ready !== 1'b1) begin bad++; $display("FAIL b2b_other_set_ready: got %0b, required 1", qry_ready); end
    exp_q.push_back({2'd0, 1'b0});
    tick();
    qry_valid = 1'b0; qry_alloc = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_same_cycle();
    do_reset();
    upd_valid = 1'b1; upd_set = 2'd2; upd_way = 2'd0; upd_op = LRU_OP_TOUCH;
    qry_valid = 1'b1; qry_set = 2'd2; qry_alloc = 1'b0;
    exp_q.push_back({2'd0, 1'b0});
    tick();
    upd_valid = 1'b0; qry_valid = 1'b0;
    send_query(2'd2, 1'b0, 4'b0000, 2'd1, 1'b0);
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_query(2'd0, 1'b1, 4'b0000, 2'd0, 1'b0);
    #1;
    reset = 1'b0;
    #1;
    total++; if (vic_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_strobe: got %0b, required 0", vic_valid); end
    total++; if (qry_ready !== 1'b1) begin bad++; $display("FAIL mid_reset_pend_clear: got %0b, required 1", qry_ready); end
    exp_q.delete();
    tick();
    tick();
    reset = 1'b1;
    send_query(2'd0, 1'b0, 4'b0000, 2'd0, 1'b0);
    tick();
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    test_reset();
    test_touch_inval();
    test_lock();
    test_back_to_back();
    test_same_cycle();
    test_reset_mid();
    tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d outstanding responses, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
